// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, state/forward encodings and forward-priority helper for hazard_unit
package hazard_pkg;

    localparam int DEF_REG_W = 5;
    localparam int MAX_STALL = 3;

    typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_t;
    typedef enum logic [1:0] {RUN, STALL, MWAIT, FLUSH} hz_state_t;

    // Nearest producer wins; an EX load has no data yet, so it never feeds the operand
    function automatic fwd_sel_t fwd_pick(input logic [2:0] m, input logic ex_load);
        return (m[0] && !ex_load) ? FWD_EX : m[1] ? FWD_MEM : m[2] ? FWD_WB : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: one ID source register against one pipeline-stage destination (r0 never matches)
module hazard_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic             used,
    input  logic [REG_W-1:0] rd,
    input  logic             we,
    output logic             match
);

    assign match = used && we && (rd == rs) && (rs != '0);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: five-stage hazard controller - stalls, memory wait, branch flush, forwarding (HAZARD_FWD_EN)
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_branch_taken,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             ex_rf_we,
    input  logic             mem_rf_we,
    input  logic             wb_rf_we,
    input  logic             ex_load,
    input  logic             mem_busy,
    output logic             nop_sel,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             ifid_clr,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       hz_state
);

    logic [REG_W-1:0] rd [3];
    logic [2:0]       we, m_a, m_b;
    hz_state_t        state, saved, eff, state_n, saved_n;
    logic [1:0]       cnt, cnt_n, extra;
    logic             hz, stall;

    assign rd = '{ex_rd, mem_rd, wb_rd};
    assign we = {wb_rf_we, mem_rf_we, ex_rf_we};

    for (genvar i = 0; i < 3; i++) begin : g_stage
        hazard_match #(.REG_W(REG_W)) u_a (.rs(id_rs1), .used(id_rs1_used), .rd(rd[i]), .we(we[i]), .match(m_a[i]));
        hazard_match #(.REG_W(REG_W)) u_b (.rs(id_rs2), .used(id_rs2_used), .rd(rd[i]), .we(we[i]), .match(m_b[i]));
    end

`ifdef HAZARD_FWD_EN
    assign hz    = ex_load && (m_a[0] || m_b[0]);
    assign extra = 2'd0;
    assign fwd_a = (!rst_n || nop_sel) ? FWD_RF : fwd_pick(m_a, ex_load);
    assign fwd_b = (!rst_n || nop_sel) ? FWD_RF : fwd_pick(m_b, ex_load);
`else
    logic unused_ex_load;
    assign unused_ex_load = ex_load;
    assign hz    = |{m_a, m_b};
    assign extra = (m_a[0] || m_b[0]) ? 2'(MAX_STALL - 1) : (m_a[1] || m_b[1]) ? 2'(MAX_STALL - 2) : 2'd0;
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    // A memory wait parks the interrupted state; once released that state acts in the same cycle
    assign eff      = (state == MWAIT) ? saved : state;
    assign stall    = (eff == STALL) || (eff == RUN && hz);
    assign hz_state = rst_n ? state : RUN;

    // Next state: mem_busy beats stalls, stalls beat a taken branch
    always_comb begin
        state_n = RUN;
        saved_n = saved;
        cnt_n   = cnt;
        if (mem_busy) begin
            state_n = MWAIT;
            saved_n = eff;
        end else if (eff == STALL) begin
            cnt_n   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
            state_n = (cnt <= 2'd1) ? RUN : STALL;
        end else if (eff == RUN && hz) begin
            cnt_n   = extra;
            state_n = (extra != 2'd0) ? STALL : RUN;
        end else if (eff == RUN && id_branch_taken) begin
            state_n = FLUSH;
        end
    end

    // Pipeline controls; reset forces a bubble and an IF-ID clear
    always_comb begin
        nop_sel  = 1'b0;
        pc_le    = 1'b1;
        ifid_le  = 1'b1;
        ifid_clr = 1'b0;
        freeze   = 1'b0;
        if (!rst_n) begin
            nop_sel  = 1'b1;
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            ifid_clr = 1'b1;
        end else if (mem_busy) begin
            freeze  = 1'b1;
            pc_le   = 1'b0;
            ifid_le = 1'b0;
        end else if (stall) begin
            nop_sel = 1'b1;
            pc_le   = 1'b0;
            ifid_le = 1'b0;
        end else if (eff == FLUSH || (eff == RUN && id_branch_taken)) begin
            ifid_clr = 1'b1;
        end
    end

    // State, saved state and stall counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            saved <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            saved <= saved_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit
module tb_hazard_unit;

    localparam logic [6:0] RUN_OK = 7'b0110000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used, id_branch_taken;
    logic       ex_rf_we, mem_rf_we, wb_rf_we, ex_load, mem_busy;
    logic       nop_sel, pc_le, ifid_le, ifid_clr, freeze;
    logic [1:0] fwd_a, fwd_b, hz_state;
    logic [6:0] ctl;
    int         checks = 0;
    int         errors = 0;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_branch_taken(id_branch_taken),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
        .ex_load(ex_load), .mem_busy(mem_busy),
        .nop_sel(nop_sel), .pc_le(pc_le), .ifid_le(ifid_le), .ifid_clr(ifid_clr),
        .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .hz_state(hz_state)
    );

    always #5 clk = ~clk;

    // {nop_sel, pc_le, ifid_le, ifid_clr, freeze, hz_state}
    assign ctl = {nop_sel, pc_le, ifid_le, ifid_clr, freeze, hz_state};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs1_used, id_rs2_used, id_branch_taken} = '0;
        {ex_rf_we, mem_rf_we, wb_rf_we, ex_load, mem_busy} = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        mem_busy = 1'b1;
        id_rs1 = 5'd3; id_rs1_used = 1'b1; ex_rd = 5'd3; ex_rf_we = 1'b1;
        step();
        checks++; if (ctl !== 7'b1001000) begin errors++; $display("FAIL reset_held: got %b expected %b", ctl, 7'b1001000); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0) begin errors++; $display("FAIL reset_fwd: got %b expected %b", {fwd_a, fwd_b}, 4'b0); end
        idle();
        rst_n = 1'b1;
        #1;
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL reset_release: got %b expected %b", ctl, RUN_OK); end
        step();
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL reset_run: got %b expected %b", ctl, RUN_OK); end
    endtask

    task automatic test_zero_reg();
        idle();
        id_rs1_used = 1'b1; ex_rf_we = 1'b1;
        id_rs2_used = 1'b1; mem_rf_we = 1'b1;
        #1;
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL r0_no_stall: got %b expected %b", ctl, RUN_OK); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL r0_fwd_a: got %0d expected 0", fwd_a); end
        step();
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL r0_next: got %b expected %b", ctl, RUN_OK); end
    endtask

    task automatic test_branch();
        idle();
        id_branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0111000) begin errors++; $display("FAIL branch_cycle: got %b expected %b", ctl, 7'b0111000); end
        step();
        id_branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== 7'b0111011) begin errors++; $display("FAIL branch_flush: got %b expected %b", ctl, 7'b0111011); end
        step();
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL branch_done: got %b expected %b", ctl, RUN_OK); end
    endtask

`ifdef HAZARD_FWD_EN
    task automatic test_load_use();
        idle();
        id_rs1 = 5'd4; id_rs1_used = 1'b1; ex_rd = 5'd4; ex_rf_we = 1'b1; ex_load = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL lu_bubble: got %b expected %b", ctl, 7'b1000000); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd: got %0d expected 0", fwd_a); end
        step();
        idle();
        id_rs1 = 5'd4; id_rs1_used = 1'b1; mem_rd = 5'd4; mem_rf_we = 1'b1;
        #1;
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL lu_resume: got %b expected %b", ctl, RUN_OK); end
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL lu_fwd_mem: got %0d expected 2", fwd_a); end
        ex_rd = 5'd4; ex_rf_we = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1; wb_rd = 5'd6; wb_rf_we = 1'b1;
        #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b0111) begin errors++; $display("FAIL fwd_prio: got %b expected %b", {fwd_a, fwd_b}, 4'b0111); end
        step();
    endtask
`else
    task automatic test_stall_len();
        logic [6:0] exp;
        for (int s = 0; s < 3; s++) begin
            idle();
            id_rs2 = 5'd7; id_rs2_used = 1'b1;
            if (s == 0) begin ex_rd = 5'd7; ex_rf_we = 1'b1; end
            if (s == 1) begin mem_rd = 5'd7; mem_rf_we = 1'b1; end
            if (s == 2) begin wb_rd = 5'd7; wb_rf_we = 1'b1; end
            #1;
            for (int k = 0; k <= 3 - s; k++) begin
                exp = (k < 3 - s) ? {5'b10000, (k > 0) ? 2'd1 : 2'd0} : RUN_OK;
                checks++; if (ctl !== exp) begin errors++; $display("FAIL stall_len s%0d k%0d: got %b expected %b", s, k, ctl, exp); end
                step();
                idle();
                #1;
            end
        end
    endtask

    task automatic test_mem_busy();
        idle();
        id_rs1 = 5'd5; id_rs1_used = 1'b1; mem_rd = 5'd5; mem_rf_we = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL mb_detect: got %b expected %b", ctl, 7'b1000000); end
        step();
        idle();
        mem_busy = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0000101) begin errors++; $display("FAIL mb_freeze1: got %b expected %b", ctl, 7'b0000101); end
        step();
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL mb_freeze2: got %b expected %b", ctl, 7'b0000110); end
        step();
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1000010) begin errors++; $display("FAIL mb_resume_bubble: got %b expected %b", ctl, 7'b1000010); end
        step();
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL mb_run: got %b expected %b", ctl, RUN_OK); end
    endtask

    task automatic test_branch_in_stall();
        idle();
        id_branch_taken = 1'b1;
        id_rs1 = 5'd9; id_rs1_used = 1'b1; ex_rd = 5'd9; ex_rf_we = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL bs_detect: got %b expected %b", ctl, 7'b1000000); end
        step();
        idle();
        id_branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1000001) begin errors++; $display("FAIL bs_stall1: got %b expected %b", ctl, 7'b1000001); end
        step();
        checks++; if (ctl !== 7'b1000001) begin errors++; $display("FAIL bs_stall2: got %b expected %b", ctl, 7'b1000001); end
        step();
        id_branch_taken = 1'b0;
        #1;
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL bs_run: got %b expected %b", ctl, RUN_OK); end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        id_rs1 = 5'd9; id_rs1_used = 1'b1; ex_rd = 5'd9; ex_rf_we = 1'b1;
        step();
        idle();
        #1;
        checks++; if (ctl !== 7'b1000001) begin errors++; $display("FAIL rs_in_stall: got %b expected %b", ctl, 7'b1000001); end
        rst_n = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1001000) begin errors++; $display("FAIL rs_forced: got %b expected %b", ctl, 7'b1001000); end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL rs_after: got %b expected %b", ctl, RUN_OK); end
        step();
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL rs_hold_run: got %b expected %b", ctl, RUN_OK); end
    endtask

    task automatic test_back_to_back();
        idle();
        id_rs2 = 5'd12; id_rs2_used = 1'b1; wb_rd = 5'd12; wb_rf_we = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL b2b_first: got %b expected %b", ctl, 7'b1000000); end
        step();
        checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL b2b_second: got %b expected %b", ctl, 7'b1000000); end
        idle();
        #1;
        checks++; if (ctl !== RUN_OK) begin errors++; $display("FAIL b2b_clear: got %b expected %b", ctl, RUN_OK); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_reg();
        test_branch();
`ifdef HAZARD_FWD_EN
        test_load_use();
`else
        test_stall_len();
        test_mem_busy();
        test_branch_in_stall();
        test_reset_mid_stall();
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
